// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RISC-V main control FSM.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    EXEC_R    = 4'd2,
    EXEC_ADDR = 4'd3,
    EXEC_BR   = 4'd4,
    MEM_RD    = 4'd5,
    MEM_WR    = 4'd6,
    WB_R      = 4'd7,
    WB_MEM    = 4'd8,
    HALT      = 4'd9
  } state_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [1:0] SRC_A_RS1    = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

  typedef struct packed {
    logic [1:0] alu_op;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic       pc_src;
    logic       pc_write;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_write;
    logic       mem_to_reg;
    logic       retire;
  } ctrl_t;

endpackage

// File: rtl/ctrl_out_decode.sv
// Combinational map from FSM state (plus the memory handshake and ALU zero
// flag) to every datapath control output; retire marks an instruction's last cycle.
module ctrl_out_decode
  import multicycle_ctrl_pkg::*;
(
  input  state_t state_i,
  input  logic   mem_ready_i,
  input  logic   zero_i,
  output ctrl_t  ctrl_o
);

  // Per-state control outputs; everything idles at zero unless set below.
  always_comb begin
    ctrl_o = '0;
    case (state_i)
      FETCH: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b0;
        ctrl_o.src_a    = SRC_A_PC;
        ctrl_o.src_b    = SRC_B_FOUR;
        ctrl_o.alu_op   = ALUOP_ADD;
        ctrl_o.pc_src   = 1'b0;
        if (mem_ready_i) begin
          ctrl_o.ir_write = 1'b1;
          ctrl_o.pc_write = 1'b1;
        end else begin
          ctrl_o.ir_write = 1'b0;
          ctrl_o.pc_write = 1'b0;
        end
      end
      DECODE: begin
        ctrl_o.src_a  = SRC_A_OLD_PC;
        ctrl_o.src_b  = SRC_B_IMM;
        ctrl_o.alu_op = ALUOP_ADD;
      end
      EXEC_R: begin
        ctrl_o.src_a  = SRC_A_RS1;
        ctrl_o.src_b  = SRC_B_RS2;
        ctrl_o.alu_op = ALUOP_FUNCT;
      end
      WB_R: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b0;
        ctrl_o.retire     = 1'b1;
      end
      EXEC_ADDR: begin
        ctrl_o.src_a  = SRC_A_RS1;
        ctrl_o.src_b  = SRC_B_IMM;
        ctrl_o.alu_op = ALUOP_ADD;
      end
      MEM_RD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      WB_MEM: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.retire     = 1'b1;
      end
      MEM_WR: begin
        // Request stays up through the whole stall; retire only on completion.
        ctrl_o.mem_write = 1'b1;
        ctrl_o.iord      = 1'b1;
        ctrl_o.retire    = mem_ready_i;
      end
      EXEC_BR: begin
        ctrl_o.src_a    = SRC_A_RS1;
        ctrl_o.src_b    = SRC_B_RS2;
        ctrl_o.alu_op   = ALUOP_SUB;
        ctrl_o.pc_src   = 1'b1;
        ctrl_o.pc_write = zero_i;
        ctrl_o.retire   = 1'b1;
      end
      HALT: begin
        ctrl_o = '0;
      end
      default: begin
        ctrl_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle RISC-V datapath: state register,
// latched opcode, sticky illegal flag and retired-instruction counter.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int INSTR_CNT_W = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [6:0]             opcode_i,
  input  logic                   zero_i,
  input  logic                   mem_ready_i,
  output logic [1:0]             ALUOp_o,
  output logic [1:0]             alu_src_a_o,
  output logic [1:0]             alu_src_b_o,
  output logic                   pc_src_o,
  output logic                   pc_write_o,
  output logic                   ir_write_o,
  output logic                   mem_read_o,
  output logic                   mem_write_o,
  output logic                   iord_o,
  output logic                   reg_write_o,
  output logic                   mem_to_reg_o,
  output logic                   illegal_o,
  output logic [INSTR_CNT_W-1:0] retired_o
);

  state_t                 state_r;
  state_t                 next_state_s;
  logic [6:0]             opcode_r;
  logic                   illegal_r;
  logic [INSTR_CNT_W-1:0] retired_r;
  ctrl_t                  dec_s;
  ctrl_t                  ctrl_s;

  ctrl_out_decode u_ctrl_out_decode (
    .state_i     (state_r),
    .mem_ready_i (mem_ready_i),
    .zero_i      (zero_i),
    .ctrl_o      (dec_s)
  );

  // Next-state selection.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      FETCH: begin
        if (mem_ready_i) next_state_s = DECODE;
        else             next_state_s = FETCH;
      end
      DECODE: begin
        case (opcode_i)
          OP_RTYPE:          next_state_s = EXEC_R;
          OP_LOAD, OP_STORE: next_state_s = EXEC_ADDR;
          OP_BRANCH:         next_state_s = EXEC_BR;
          default:           next_state_s = HALT;
        endcase
      end
      EXEC_R:    next_state_s = WB_R;
      WB_R:      next_state_s = FETCH;
      EXEC_ADDR: begin
        // The IR opcode may already be stale here, so use the DECODE copy.
        if (opcode_r == OP_LOAD) next_state_s = MEM_RD;
        else                     next_state_s = MEM_WR;
      end
      MEM_RD: begin
        if (mem_ready_i) next_state_s = WB_MEM;
        else             next_state_s = MEM_RD;
      end
      WB_MEM: next_state_s = FETCH;
      MEM_WR: begin
        if (mem_ready_i) next_state_s = FETCH;
        else             next_state_s = MEM_WR;
      end
      EXEC_BR: next_state_s = FETCH;
      HALT:    next_state_s = HALT;
      default: next_state_s = FETCH;
    endcase
  end

  // State, opcode latch, sticky illegal flag and retire counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r   <= FETCH;
      opcode_r  <= 7'd0;
      illegal_r <= 1'b0;
      retired_r <= '0;
    end else begin
      state_r   <= next_state_s;
      illegal_r <= (next_state_s == HALT);
      if (state_r == DECODE) opcode_r <= opcode_i;
      else                   opcode_r <= opcode_r;
      if (dec_s.retire) retired_r <= retired_r + INSTR_CNT_W'(1);
      else              retired_r <= retired_r;
    end
  end

  // Reset forces every control output low without waiting for a clock edge.
  always_comb begin
    if (rst_i) ctrl_s = '0;
    else       ctrl_s = dec_s;
  end

  assign ALUOp_o      = ctrl_s.alu_op;
  assign alu_src_a_o  = ctrl_s.src_a;
  assign alu_src_b_o  = ctrl_s.src_b;
  assign pc_src_o     = ctrl_s.pc_src;
  assign pc_write_o   = ctrl_s.pc_write;
  assign ir_write_o   = ctrl_s.ir_write;
  assign mem_read_o   = ctrl_s.mem_read;
  assign mem_write_o  = ctrl_s.mem_write;
  assign iord_o       = ctrl_s.iord;
  assign reg_write_o  = ctrl_s.reg_write;
  assign mem_to_reg_o = ctrl_s.mem_to_reg;
  assign illegal_o    = illegal_r;
  assign retired_o    = retired_r;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the multi-cycle RISC-V datapath.
- Sits directly upstream of the ALU control decoder.
- Sequences each instruction through fetch, decode, execute, memory and write-back.
- Each cycle it drives the 2-bit ALUOp (00 add, 01 subtract, 10 funct-decoded) together with all datapath mux selects and write enables.
- Memory accesses stall on a ready handshake; unsupported opcodes trap to a sticky halt.

Parameters:
- INSTR_CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, asynchronous and active-high.
- opcode_i  input  7  instruction-register opcode field; sampled only in DECODE.
- zero_i  input  1  ALU zero flag; used in EXEC_BR only.
- mem_ready_i  input  1  memory completes the current access this cycle.
- ALUOp_o  output  2  ALU operation class, to the ALU control decoder.
- alu_src_a_o  output  2  ALU A select: 00 PC, 01 old PC, 10 rs1.
- alu_src_b_o  output  2  ALU B select: 00 rs2, 01 constant 4, 10 immediate.
- pc_src_o  output  1  PC source: 0 ALU result, 1 ALUOut register.
- pc_write_o  output  1  PC write enable, with the branch condition already folded in.
- ir_write_o  output  1  instruction-register and old-PC latch enable.
- mem_read_o  output  1  memory read request.
- mem_write_o  output  1  memory write request.
- iord_o  output  1  memory address select: 0 PC, 1 ALUOut.
- reg_write_o  output  1  register-file write enable.
- mem_to_reg_o  output  1  write-back select: 0 ALUOut, 1 MDR.
- illegal_o  output  1  sticky flag: halted on an unsupported opcode.
- retired_o  output  INSTR_CNT_W  retired-instruction count.

Behaviour:
- Reset values:
  - State = FETCH; retired_o = 0; illegal_o = 0.
  - While rst_i is high, all enables and requests are 0; ALUOp_o and all selects are 00/0.
- Reset asserted mid-instruction aborts immediately. No partial write completes after the reset edge. After release, execution restarts in FETCH.
- Outputs are Moore (a function of state only), except two that also depend on inputs:
  - pc_write_o, ir_write_o and the FETCH-to-DECODE transition are qualified by mem_ready_i.
  - pc_write_o in EXEC_BR is qualified by zero_i.
- FETCH:
  - mem_read=1, iord=0, srcA=PC, srcB=4, ALUOp=00, pc_src=0.
  - If mem_ready_i=1: ir_write=1, pc_write=1, go to DECODE. Otherwise hold with no writes.
- DECODE:
  - srcA=old PC, srcB=imm, ALUOp=00; branch target is latched into ALUOut.
  - Next state by opcode:
    - 0110011 → EXEC_R
    - 0000011 or 0100011 → EXEC_ADDR
    - 1100011 → EXEC_BR
    - anything else → HALT
- EXEC_R: srcA=rs1, srcB=rs2, ALUOp=10; go to WB_R.
- WB_R: reg_write=1, mem_to_reg=0; retire; go to FETCH.
- EXEC_ADDR: srcA=rs1, srcB=imm, ALUOp=00. Go to MEM_RD for a load, MEM_WR for a store. The opcode is held in an internal register latched in DECODE.
- MEM_RD: mem_read=1, iord=1. Hold until mem_ready_i=1, then go to WB_MEM.
- WB_MEM: reg_write=1, mem_to_reg=1; retire; go to FETCH.
- MEM_WR: mem_write=1, iord=1. Hold until mem_ready_i=1, then retire and go to FETCH. mem_write stays asserted for the entire stall.
- EXEC_BR:
  - srcA=rs1, srcB=rs2, ALUOp=01, pc_src=1, pc_write=zero_i.
  - Retire; go to FETCH.
- HALT:
  - illegal_o=1; all enables 0.
  - Stays in HALT until reset; no retire.
- Retire:
  - retired_o increments by 1 on the last cycle of each instruction.
  - Wraps modulo 2^INSTR_CNT_W with no flag.
- Latency with mem_ready_i tied high: R-type 4 cycles, load 5, store 4, branch 3. Each stall cycle in FETCH, MEM_RD or MEM_WR adds exactly 1.
- No two of mem_read_o, mem_write_o, reg_write_o are ever high together.

Decomposition:
- Shared package holds:
  - state enum: FETCH, DECODE, EXEC_R, EXEC_ADDR, EXEC_BR, MEM_RD, MEM_WR, WB_R, WB_MEM, HALT;
  - opcode constants;
  - ALUOp constants 00/01/10;
  - src-A and src-B select encodings.
- One combinational sub-module, ctrl_out_decode, maps (state, mem_ready_i, zero_i) to the control outputs. The top level keeps the state register, latched opcode and retire counter.

Test Plan:
- Reset, mem_ready=1, opcode 0110011:
  - States FETCH→DECODE→EXEC_R→WB_R.
  - ALUOp sequence 00,00,10,00; reg_write high only in cycle 4; retired=1.
- Opcode 0000011, mem_ready low for 3 cycles in MEM_RD:
  - Load takes 8 cycles; mem_read high and iord=1 throughout MEM_RD.
  - mem_to_reg=1 with reg_write in WB_MEM.
- Opcode 1100011:
  - zero_i=1 in EXEC_BR → pc_write=1, pc_src=1, ALUOp=01.
  - Repeat with zero_i=0 → pc_write=0; both retire in 3 cycles.
- Opcode 0100011 with a 2-cycle mem_ready stall → mem_write held for 3 cycles, no reg_write; retired increments once.
- Opcode 1111111 → HALT, illegal_o=1, retired frozen; rst_i pulse returns to FETCH with illegal_o=0.
- rst_i asserted asynchronously in MEM_WR → mem_write_o drops immediately without waiting for a clock edge, retired_o=0, restart in FETCH.
